row_data_loader: RTL and testbench

Upstream feeder for the LED controller. Accepts a byte stream from the host interface via a valid/ready handshake and parses row packets. Each packet is one header byte carrying the panel and row address, followed by 64 payload bytes. The block assembles the payload into sixteen 32-bit chunks and drives them onto the controller's chunk-write port, with the panel/row address held stable for the whole packet.

---
 rtl/row_data_loader_pkg.sv | 26 ++
 rtl/row_data_loader_byte_packer.sv | 35 +++
 rtl/row_data_loader.sv | 194 +++++++++++++++++++
 tb/tb_row_data_loader.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/row_data_loader_pkg.sv
// Shared definitions for the row data loader: header field layout,
// row geometry and the parser state encoding.
package row_data_loader_pkg;

  // Header byte field positions
  localparam int SYNC_BIT  = 7;
  localparam int PANEL_MSB = 5;
  localparam int PANEL_LSB = 4;
  localparam int ROW_MSB   = 3;
  localparam int ROW_LSB   = 0;

  // Row geometry
  localparam int CHUNKS_PER_ROW  = 16;
  localparam int BYTES_PER_CHUNK = 4;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_t;

  // A byte is a header candidate when its sync marker is set
  function automatic logic is_header(input logic [7:0] b);
    return b[SYNC_BIT];
  endfunction

endpackage

// File: rtl/row_data_loader_byte_packer.sv
// Packs a strobed byte stream into big-endian 32-bit words. The completed
// word is presented combinationally together with the 4th byte so the
// caller can register it in the same cycle the byte is accepted.
module row_data_loader_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_done
);

  logic [23:0] shift_r;
  logic [1:0]  count_r;

  // The first three bytes sit in shift_r; the current byte fills [7:0]
  assign word      = {shift_r, byte_data};
  assign word_done = byte_valid & (count_r == 2'd3);

  // Shift in bytes and track position within the word; clear realigns
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift_r <= 24'd0;
      count_r <= 2'd0;
    end else if (byte_valid) begin
      shift_r <= {shift_r[15:0], byte_data};
      count_r <= count_r + 2'd1;
    end else begin
      shift_r <= shift_r;
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/row_data_loader.sv
// Row packet parser feeding the LED controller chunk-write port. A header
// byte selects panel/row, then 64 payload bytes become sixteen 32-bit
// chunk writes. Idle gaps longer than TIMEOUT_CYCLES abort the packet.
module row_data_loader
  import row_data_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ERR_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      chunk_data,
  output logic [3:0]       chunk_data_addr,
  output logic             chunk_data_write_enable,
  output logic [3:0]       row_data_row_addr,
  output logic [1:0]       row_data_panel_addr,
  output logic             row_done,
  output logic [ERR_W-1:0] error_count
);

  localparam int            TW           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0]    LAST_BYTE    = 6'(CHUNKS_PER_ROW * BYTES_PER_CHUNK - 1);

  state_t            state_r;
  state_t            state_s;
  logic              in_ready_r;
  logic              accept_s;
  logic              hdr_accept_s;
  logic              bad_hdr_s;
  logic              payload_s;
  logic              abort_s;
  logic [5:0]        byte_cnt_r;
  logic [TW-1:0]     timer_r;
  logic [31:0]       pack_word_s;
  logic              pack_done_s;
  logic [31:0]       chunk_data_r;
  logic [3:0]        chunk_addr_r;
  logic              chunk_we_r;
  logic              row_done_r;
  logic [3:0]        row_addr_r;
  logic [1:0]        panel_addr_r;
  logic [ERR_W-1:0]  error_count_r;

  assign accept_s = in_valid & in_ready_r;

  row_data_loader_byte_packer u_byte_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (hdr_accept_s),
    .byte_valid (payload_s),
    .byte_data  (in_data),
    .word       (pack_word_s),
    .word_done  (pack_done_s)
  );

  // Parser state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= HUNT;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and per-cycle event decode; an accepted byte beats timeout
  always_comb begin
    state_s      = state_r;
    hdr_accept_s = 1'b0;
    bad_hdr_s    = 1'b0;
    payload_s    = 1'b0;
    abort_s      = 1'b0;
    case (state_r)
      HUNT: begin
        if (accept_s) begin
          if (is_header(in_data)) begin
            hdr_accept_s = 1'b1;
            state_s      = DATA;
          end else begin
            bad_hdr_s = 1'b1;
            state_s   = HUNT;
          end
        end else begin
          state_s = HUNT;
        end
      end
      DATA: begin
        if (accept_s) begin
          payload_s = 1'b1;
          if (byte_cnt_r == LAST_BYTE) begin
            state_s = HUNT;
          end else begin
            state_s = DATA;
          end
        end else if (timer_r == TIMEOUT_LAST) begin
          abort_s = 1'b1;
          state_s = HUNT;
        end else begin
          state_s = DATA;
        end
      end
      default: begin
        state_s = HUNT;
      end
    endcase
  end

  // Ready is low only while reset is asserted
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_r <= 1'b0;
    end else begin
      in_ready_r <= 1'b1;
    end
  end

  // Payload byte position within the packet
  always_ff @(posedge clk) begin
    if (reset || hdr_accept_s) begin
      byte_cnt_r <= 6'd0;
    end else if (payload_s) begin
      byte_cnt_r <= byte_cnt_r + 6'd1;
    end else begin
      byte_cnt_r <= byte_cnt_r;
    end
  end

  // Idle-gap counter: runs only in DATA, cleared by any accepted byte
  always_ff @(posedge clk) begin
    if (reset || accept_s || abort_s || (state_r != DATA)) begin
      timer_r <= '0;
    end else begin
      timer_r <= timer_r + TW'(1);
    end
  end

  // Chunk write port: strobe one cycle after the 4th byte of a chunk
  always_ff @(posedge clk) begin
    if (reset) begin
      chunk_we_r   <= 1'b0;
      row_done_r   <= 1'b0;
      chunk_data_r <= 32'd0;
      chunk_addr_r <= 4'd0;
    end else begin
      chunk_we_r <= pack_done_s;
      row_done_r <= pack_done_s & (byte_cnt_r == LAST_BYTE);
      if (pack_done_s) begin
        chunk_data_r <= pack_word_s;
        chunk_addr_r <= byte_cnt_r[5:2];
      end else begin
        chunk_data_r <= chunk_data_r;
        chunk_addr_r <= chunk_addr_r;
      end
    end
  end

  // Panel/row address, updated only when a header is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      panel_addr_r <= 2'd0;
      row_addr_r   <= 4'd0;
    end else if (hdr_accept_s) begin
      panel_addr_r <= in_data[PANEL_MSB:PANEL_LSB];
      row_addr_r   <= in_data[ROW_MSB:ROW_LSB];
    end else begin
      panel_addr_r <= panel_addr_r;
      row_addr_r   <= row_addr_r;
    end
  end

  // Saturating count of discarded header bytes and aborted packets
  always_ff @(posedge clk) begin
    if (reset) begin
      error_count_r <= '0;
    end else if ((bad_hdr_s || abort_s) && (error_count_r != {ERR_W{1'b1}})) begin
      error_count_r <= error_count_r + ERR_W'(1);
    end else begin
      error_count_r <= error_count_r;
    end
  end

  assign in_ready                = in_ready_r;
  assign chunk_data              = chunk_data_r;
  assign chunk_data_addr         = chunk_addr_r;
  assign chunk_data_write_enable = chunk_we_r;
  assign row_done                = row_done_r;
  assign row_data_row_addr       = row_addr_r;
  assign row_data_panel_addr     = panel_addr_r;
  assign error_count             = error_count_r;

endmodule

// File: tb/tb_row_data_loader.sv
// Self-checking bench for row_data_loader. A packet-level reference model
// (byte list per packet, idle-gap count) predicts every output each cycle.
module tb_row_data_loader;

  localparam int TO    = 1024;
  localparam int ERR_W = 8;

  logic             clk;
  logic             reset;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      chunk_data;
  logic [3:0]       chunk_data_addr;
  logic             chunk_data_write_enable;
  logic [3:0]       row_data_row_addr;
  logic [1:0]       row_data_panel_addr;
  logic             row_done;
  logic [ERR_W-1:0] error_count;

  int checks = 0;
  int errors = 0;

  row_data_loader #(.TIMEOUT_CYCLES(TO), .ERR_W(ERR_W)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .in_data                 (in_data),
    .in_valid                (in_valid),
    .in_ready                (in_ready),
    .chunk_data              (chunk_data),
    .chunk_data_addr         (chunk_data_addr),
    .chunk_data_write_enable (chunk_data_write_enable),
    .row_data_row_addr       (row_data_row_addr),
    .row_data_panel_addr     (row_data_panel_addr),
    .row_done                (row_done),
    .error_count             (error_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic        m_started = 1'b0;
  logic        m_rdy     = 1'b0;
  logic        m_hunt    = 1'b1;
  logic [7:0]  m_bytes [0:63];
  int          m_n     = 0;
  int          m_idle  = 0;
  int          m_err   = 0;
  logic [1:0]  m_panel = 2'd0;
  logic [3:0]  m_row   = 4'd0;
  logic [31:0] m_chunk = 32'd0;
  logic [3:0]  m_caddr = 4'd0;
  logic        m_we    = 1'b0;
  logic        m_done  = 1'b0;

  // Advance the model by one clock edge given the inputs held before it
  task automatic model_step(input logic v, input logic [7:0] d, input logic r);
    m_we   = 1'b0;
    m_done = 1'b0;
    if (r) begin
      m_started = 1'b1;
      m_rdy = 1'b0; m_hunt = 1'b1; m_n = 0; m_idle = 0; m_err = 0;
      m_panel = 2'd0; m_row = 4'd0; m_chunk = 32'd0; m_caddr = 4'd0;
    end else begin
      if (m_hunt) begin
        if (v && m_rdy) begin
          if (d[7]) begin
            m_panel = d[5:4]; m_row = d[3:0];
            m_hunt = 1'b0; m_n = 0; m_idle = 0;
          end else if (m_err < 255) begin
            m_err++;
          end
        end
      end else if (v && m_rdy) begin
        m_bytes[m_n] = d;
        m_n++;
        m_idle = 0;
        if (m_n % 4 == 0) begin
          m_chunk = {m_bytes[m_n-4], m_bytes[m_n-3], m_bytes[m_n-2], m_bytes[m_n-1]};
          m_caddr = 4'(m_n / 4 - 1);
          m_we    = 1'b1;
          m_done  = (m_n == 64);
          if (m_n == 64) m_hunt = 1'b1;
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          m_hunt = 1'b1;
          if (m_err < 255) m_err++;
        end
      end
      m_rdy = 1'b1;
    end
  endtask

  // One clock cycle of stimulus
  task automatic tick(input logic v, input logic [7:0] d, input logic r);
    in_valid = v; in_data = d; reset = r;
    @(posedge clk);
    model_step(v, d, r);
    #1;
  endtask

  // ---------------- per-cycle monitor ----------------
  int          n_we = 0;
  int          n_done = 0;
  logic [31:0] cap [0:15];
  logic [3:0]  last_done_addr = 4'd0;

  always @(negedge clk) begin
    if (m_started) begin
      checks++;
      if (chunk_data_write_enable !== m_we) begin
        errors++; $display("FAIL we: got %b want %b at %0t", chunk_data_write_enable, m_we, $time);
      end
      checks++;
      if (row_done !== m_done) begin
        errors++; $display("FAIL row_done: got %b want %b at %0t", row_done, m_done, $time);
      end
      checks++;
      if (chunk_data !== m_chunk || chunk_data_addr !== m_caddr) begin
        errors++; $display("FAIL chunk: got %h@%0d want %h@%0d at %0t", chunk_data, chunk_data_addr, m_chunk, m_caddr, $time);
      end
      checks++;
      if (row_data_panel_addr !== m_panel || row_data_row_addr !== m_row) begin
        errors++; $display("FAIL addr: got p%0d r%0d want p%0d r%0d at %0t", row_data_panel_addr, row_data_row_addr, m_panel, m_row, $time);
      end
      checks++;
      if (error_count !== ERR_W'(m_err) || in_ready !== m_rdy) begin
        errors++; $display("FAIL err/ready: got %0d/%b want %0d/%b at %0t", error_count, in_ready, m_err, m_rdy, $time);
      end
      if (chunk_data_write_enable === 1'b1) begin
        n_we++;
        cap[chunk_data_addr] = chunk_data;
        if (row_done === 1'b1) begin
          n_done++;
          last_done_addr = chunk_data_addr;
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic send_random_payload(input int nbytes);
    for (int i = 0; i < nbytes; i++) tick(1'b1, 8'($urandom), 1'b0);
  endtask

  task automatic test_reset;
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    checks++;
    if (in_ready !== 1'b0 || chunk_data_write_enable !== 1'b0 || error_count !== 8'd0 || chunk_data !== 32'd0) begin
      errors++; $display("FAIL reset_values: ready %b we %b err %0d chunk %h want 0", in_ready, chunk_data_write_enable, error_count, chunk_data);
    end
    tick(1'b0, 8'h00, 1'b0);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: got %b want 1", in_ready);
    end
  endtask

  task automatic test_known_packet;
    int w0, d0;
    w0 = n_we; d0 = n_done;
    tick(1'b1, 8'hB5, 1'b0);
    for (int i = 0; i < 64; i++) tick(1'b1, 8'(i), 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    checks++;
    if (n_we - w0 != 16 || n_done - d0 != 1 || last_done_addr !== 4'd15) begin
      errors++; $display("FAIL known_counts: strobes %0d done %0d done_addr %0d want 16 1 15", n_we - w0, n_done - d0, last_done_addr);
    end
    checks++;
    if (row_data_panel_addr !== 2'd3 || row_data_row_addr !== 4'd5) begin
      errors++; $display("FAIL known_addr: got p%0d r%0d want p3 r5", row_data_panel_addr, row_data_row_addr);
    end
    checks++;
    if (cap[0] !== 32'h00010203 || cap[15] !== 32'h3C3D3E3F) begin
      errors++; $display("FAIL known_data: chunk0 %h chunk15 %h want 00010203 3c3d3e3f", cap[0], cap[15]);
    end
  endtask

  task automatic test_bad_headers;
    int d0;
    tick(1'b1, 8'h12, 1'b0);
    tick(1'b1, 8'h7F, 1'b0);
    checks++;
    if (error_count !== 8'd2 || row_data_panel_addr !== 2'd3 || row_data_row_addr !== 4'd5) begin
      errors++; $display("FAIL bad_hdr: err %0d p%0d r%0d want 2 p3 r5", error_count, row_data_panel_addr, row_data_row_addr);
    end
    d0 = n_done;
    tick(1'b1, 8'h9A, 1'b0);
    send_random_payload(64);
    tick(1'b0, 8'h00, 1'b0);
    checks++;
    if (n_done - d0 != 1 || row_data_panel_addr !== 2'd1 || row_data_row_addr !== 4'd10 || error_count !== 8'd2) begin
      errors++; $display("FAIL bad_hdr_next: done %0d p%0d r%0d err %0d want 1 p1 r10 2", n_done - d0, row_data_panel_addr, row_data_row_addr, error_count);
    end
  endtask

  task automatic test_timeout;
    int w0, d0;
    w0 = n_we; d0 = n_done;
    tick(1'b1, 8'hE7, 1'b0);
    send_random_payload(10);
    for (int i = 0; i < TO - 1; i++) tick(1'b0, 8'h00, 1'b0);
    checks++;
    if (error_count !== 8'd2) begin
      errors++; $display("FAIL timeout_early: err %0d want 2", error_count);
    end
    tick(1'b0, 8'h00, 1'b0);
    checks++;
    if (error_count !== 8'd3 || n_we - w0 != 2 || n_done - d0 != 0) begin
      errors++; $display("FAIL timeout_abort: err %0d strobes %0d done %0d want 3 2 0", error_count, n_we - w0, n_done - d0);
    end
    // Byte arriving on the expiry cycle wins over the timeout
    d0 = n_done;
    tick(1'b1, 8'h85, 1'b0);
    tick(1'b1, 8'h11, 1'b0);
    for (int i = 0; i < TO - 1; i++) tick(1'b0, 8'h00, 1'b0);
    send_random_payload(63);
    tick(1'b0, 8'h00, 1'b0);
    checks++;
    if (n_done - d0 != 1 || error_count !== 8'd3 || row_data_row_addr !== 4'd5 || row_data_panel_addr !== 2'd0) begin
      errors++; $display("FAIL timeout_byte_wins: done %0d err %0d r%0d p%0d want 1 3 r5 p0", n_done - d0, error_count, row_data_row_addr, row_data_panel_addr);
    end
  endtask

  task automatic test_back_to_back;
    int w0, d0;
    logic [7:0] h1, h2;
    w0 = n_we; d0 = n_done;
    h1 = 8'($urandom) | 8'h80;
    h2 = 8'($urandom) | 8'h80;
    tick(1'b1, h1, 1'b0);
    send_random_payload(64);
    checks++;
    if (row_data_panel_addr !== h1[5:4] || row_data_row_addr !== h1[3:0]) begin
      errors++; $display("FAIL b2b_first_addr: got p%0d r%0d want p%0d r%0d", row_data_panel_addr, row_data_row_addr, h1[5:4], h1[3:0]);
    end
    tick(1'b1, h2, 1'b0);
    send_random_payload(64);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    checks++;
    if (n_we - w0 != 32 || n_done - d0 != 2 || row_data_panel_addr !== h2[5:4] || row_data_row_addr !== h2[3:0]) begin
      errors++; $display("FAIL b2b: strobes %0d done %0d p%0d r%0d want 32 2 p%0d r%0d", n_we - w0, n_done - d0, row_data_panel_addr, row_data_row_addr, h2[5:4], h2[3:0]);
    end
  endtask

  task automatic test_random_stream;
    for (int i = 0; i < 800; i++) begin
      tick(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, 8'($urandom), 1'b0);
    end
    tick(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid_packet;
    int w0, d0;
    tick(1'b1, 8'hA3, 1'b0);
    send_random_payload(31);
    tick(1'b0, 8'h00, 1'b1);
    checks++;
    if (in_ready !== 1'b0 || chunk_data_write_enable !== 1'b0 || row_done !== 1'b0 || chunk_data !== 32'd0 ||
        chunk_data_addr !== 4'd0 || row_data_panel_addr !== 2'd0 || row_data_row_addr !== 4'd0 || error_count !== 8'd0) begin
      errors++; $display("FAIL mid_reset_clear: ready %b we %b done %b chunk %h a%0d p%0d r%0d err %0d want all 0",
                         in_ready, chunk_data_write_enable, row_done, chunk_data, chunk_data_addr,
                         row_data_panel_addr, row_data_row_addr, error_count);
    end
    w0 = n_we;
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    checks++;
    if (n_we - w0 != 0) begin
      errors++; $display("FAIL mid_reset_no_strobe: strobes %0d want 0", n_we - w0);
    end
    w0 = n_we; d0 = n_done;
    tick(1'b1, 8'hC9, 1'b0);
    send_random_payload(64);
    tick(1'b0, 8'h00, 1'b0);
    checks++;
    if (n_we - w0 != 16 || n_done - d0 != 1 || row_data_panel_addr !== 2'd0 || row_data_row_addr !== 4'd9) begin
      errors++; $display("FAIL mid_reset_fresh: strobes %0d done %0d p%0d r%0d want 16 1 p0 r9", n_we - w0, n_done - d0, row_data_panel_addr, row_data_row_addr);
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 254; i++) tick(1'b1, 8'($urandom) & 8'h7F, 1'b0);
    checks++;
    if (error_count !== 8'd254) begin
      errors++; $display("FAIL sat_254: got %0d want 254", error_count);
    end
    tick(1'b1, 8'h00, 1'b0);
    checks++;
    if (error_count !== 8'd255) begin
      errors++; $display("FAIL sat_255: got %0d want 255", error_count);
    end
    for (int i = 0; i < 45; i++) tick(1'b1, 8'($urandom) & 8'h7F, 1'b0);
    checks++;
    if (error_count !== 8'd255) begin
      errors++; $display("FAIL sat_hold: got %0d want 255", error_count);
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int i = 0; i < 16; i++) cap[i] = 32'd0;
    test_reset();
    test_known_packet();
    test_bad_headers();
    test_timeout();
    test_back_to_back();
    test_random_stream();
    test_reset_mid_packet();
    test_saturation();
    tick(1'b0, 8'h00, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
